game_fsm_multi: RTL and testbench
=================================

GAME_FSM_MULTI -- requirements
Module: game_fsm_multi

Interface
REQ-001 The block SHALL provide parameter NUM_PIPES, default 3, the number of pipe channels monitored.
REQ-002 The block SHALL provide parameter SCORE_W, default 12, the width of score and high_score.
REQ-003 The block SHALL provide parameter LIVES, default 3 (range 1..15), the lives granted per game.
REQ-004 The block SHALL provide parameter RESPAWN_FRAMES, default 60 (≥1), the frame count spent in DYING.
REQ-005 The block SHALL have port clk, input, 1, the single system clock.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port vs, input, 1, vertical sync level; its rising edge marks one frame.
REQ-008 The block SHALL have ports start, pause, restart, input, 1 each, synchronous button levels.
REQ-009 The block SHALL have port crash_vec, input, NUM_PIPES, per-pipe collision level.
REQ-010 The block SHALL have port pass_vec, input, NUM_PIPES, per-pipe "bird past pipe" level.
REQ-011 The block SHALL have outputs waiting, play, paused, dying, over, 1 each, one-hot state flags.
REQ-012 The block SHALL have output bird_en, 1, a one-cycle pulse on a vs rising edge while play=1.
REQ-013 The block SHALL have outputs score and high_score, SCORE_W each, and lives_left, 4.
REQ-014 The block SHALL have output new_record, 1, a one-cycle pulse when high_score is updated.

Function
REQ-015 The block SHALL derive rising-edge pulses x_p = x & ~x_d for vs, start, pause, restart and each pass_vec bit, with every x_d register reset to 0.
REQ-016 The state register SHALL hold IDLE, PLAYING, PAUSED, DYING or GAMEOVER; the flags SHALL be Moore decodes of it, valid in the cycle after the transition edge.
REQ-017 IDLE: start_p → PLAYING; all other inputs ignored.
REQ-018 PLAYING: any crash_vec bit = 1 → lives_left decrements; if the result is 0 → GAMEOVER, else → DYING with the frame counter cleared.
REQ-019 PLAYING: pause_p with no crash → PAUSED; crash has priority over pause in the same cycle.
REQ-020 PAUSED: pause_p → PLAYING; restart_p → IDLE; restart has priority; crash and pass are ignored.
REQ-021 DYING: the counter increments on each vs_p, and on the vs_p that brings it to RESPAWN_FRAMES the block SHALL go → PLAYING; crash, pass and pause are ignored.
REQ-022 GAMEOVER: restart_p → IDLE; otherwise the block SHALL hold.
REQ-023 Entry to IDLE (including from reset) SHALL set score=0 and lives_left=LIVES and SHALL leave high_score unchanged.
REQ-024 In PLAYING with no crash, score SHALL add the popcount of the pass pulses that cycle, saturating at 2^SCORE_W−1.
REQ-025 A pass in the same cycle as a crash SHALL NOT be scored.
REQ-026 On the cycle of entering GAMEOVER, if score > high_score, high_score SHALL be loaded with score and new_record SHALL pulse for one cycle; equality SHALL NOT update.
REQ-027 bird_en SHALL equal vs_p & (state==PLAYING).
REQ-028 Unused state encodings SHALL recover to IDLE on the next clk edge.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force state=IDLE, score=0, high_score=0, lives_left=LIVES, counter=0, every x_d=0, and bird_en=new_record=0.
REQ-030 While in reset, flags SHALL read waiting=1 and all others 0, and a reset mid-game SHALL discard all progress.
REQ-031 A start level held high across reset release SHALL produce start_p on the first clocked cycle.

Structure
REQ-032 The state enum and the flag encoding SHALL live in shared package game_pkg.
REQ-033 Edge detection SHALL be one sub-module, edge_rise, parametrised in width and instantiated for pass_vec (NUM_PIPES bits) and for the 4 control inputs.
REQ-034 Crash/pass geometry SHALL remain in the existing checker, outside this block.

Verification (NUM_PIPES=3, LIVES=3, RESPAWN_FRAMES=4, SCORE_W=12)
REQ-035 Bench SHALL apply reset then start pulse, and SHALL require waiting→play one cycle after the edge, score=0 and lives_left=3.
REQ-036 Bench SHALL raise pass_vec=3'b101 in one cycle, then 3'b111 next, and SHALL require score +2 then +1 (total 3), with the held bits not recounted.
REQ-037 Bench SHALL assert crash with score=5 and lives=3, and SHALL require dying=1 and lives_left=2; after 4 vs edges, play=1; crash during DYING SHALL leave lives unchanged.
REQ-038 Bench SHALL drive three crashes, and SHALL require over=1, lives_left=0, high_score=score and a new_record pulse; after restart and a lower second game, high_score SHALL be unchanged with no pulse.
REQ-039 Bench SHALL assert pause and crash in the same cycle, and SHALL require DYING, not PAUSED; pause while PLAYING SHALL yield paused=1, bird_en stuck at 0, and pass ignored.
REQ-040 Bench SHALL preload score=4094 and pass 3 pipes at once, and SHALL require score=4095 (saturated); rst_n low mid-DYING SHALL give waiting=1, score=0, high_score=0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game control FSM.
//   state_t      : game state encoding
//   F_* / FLAG_W : bit positions of the one-hot state flag vector
//   state_flags(): Moore decode of a state into that flag vector
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAYING  = 3'd1,
        ST_PAUSED   = 3'd2,
        ST_DYING    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam int FLAG_W    = 5;
    localparam int F_WAITING = 0;
    localparam int F_PLAY    = 1;
    localparam int F_PAUSED  = 2;
    localparam int F_DYING   = 3;
    localparam int F_OVER    = 4;

    // Unused encodings decode to all-zero flags for the single cycle
    // before the FSM pulls them back to IDLE.
    function automatic logic [FLAG_W-1:0] state_flags(input state_t s);
        logic [FLAG_W-1:0] f;
        f = '0;
        case (s)
            ST_IDLE:     f[F_WAITING] = 1'b1;
            ST_PLAYING:  f[F_PLAY]    = 1'b1;
            ST_PAUSED:   f[F_PAUSED]  = 1'b1;
            ST_DYING:    f[F_DYING]   = 1'b1;
            ST_GAMEOVER: f[F_OVER]    = 1'b1;
            default:     f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// edge_rise -- W-bit rising-edge detector.
//   clk, rst_n : clock, async active-low reset (delay register clears to 0)
//   d          : level inputs
//   p          : p = d & ~d_delayed, combinational; a level already high when
//                reset releases yields a pulse on the first clocked cycle.
module edge_rise #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] p
);

    logic [W-1:0] d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= '0;
        else        d_q <= d;
    end

    assign p = d & ~d_q;

endmodule

// File: rtl/game_fsm_multi.sv
// game_fsm_multi -- game control FSM with multi-pipe scoring.
//   clk, rst_n        : clock, async active-low reset
//   vs                : vertical sync level, rising edge = one frame
//   start/pause/restart : button levels (rising edge acts)
//   crash_vec         : per-pipe collision level
//   pass_vec          : per-pipe "bird past pipe" level (rising edge scores)
//   waiting/play/paused/dying/over : one-hot Moore state flags
//   bird_en           : frame pulse while playing
//   score/high_score  : current and best score, lives_left : remaining lives
//   new_record        : one-cycle pulse when high_score is loaded
module game_fsm_multi
    import game_pkg::*;
#(
    parameter int NUM_PIPES      = 3,
    parameter int SCORE_W        = 12,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vs,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 restart,
    input  logic [NUM_PIPES-1:0] crash_vec,
    input  logic [NUM_PIPES-1:0] pass_vec,
    output logic                 waiting,
    output logic                 play,
    output logic                 paused,
    output logic                 dying,
    output logic                 over,
    output logic                 bird_en,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   high_score,
    output logic [3:0]           lives_left,
    output logic                 new_record
);

    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);
    localparam int PC_W  = $clog2(NUM_PIPES + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(RESPAWN_FRAMES);

    // ---- edge detection ----
    logic [3:0]           ctl_p;
    logic [NUM_PIPES-1:0] pass_p;
    logic                 vs_p, start_p, pause_p, restart_p;

    edge_rise #(.W(4)) u_ctl_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({restart, pause, start, vs}),
        .p     (ctl_p)
    );

    edge_rise #(.W(NUM_PIPES)) u_pass_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pass_vec),
        .p     (pass_p)
    );

    assign vs_p      = ctl_p[0];
    assign start_p   = ctl_p[1];
    assign pause_p   = ctl_p[2];
    assign restart_p = ctl_p[3];

    // ---- scoring arithmetic ----
    logic [PC_W-1:0]    pass_cnt;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic               crash;

    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++)
            pass_cnt = pass_cnt + PC_W'(pass_p[i]);
    end

    assign crash     = |crash_vec;
    assign score_sum = {1'b0, score} + (SCORE_W+1)'(pass_cnt);
    assign score_sat = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

    // ---- FSM ----
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_d, high_d;
    logic [3:0]         lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nrec_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            score      <= '0;
            high_score <= '0;
            lives_left <= LIVES_INIT;
            cnt_q      <= '0;
            new_record <= 1'b0;
        end else begin
            state_q    <= state_d;
            score      <= score_d;
            high_score <= high_d;
            lives_left <= lives_d;
            cnt_q      <= cnt_d;
            new_record <= nrec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score;
        high_d  = high_score;
        lives_d = lives_left;
        cnt_d   = cnt_q;
        nrec_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_p) state_d = ST_PLAYING;
            end
            ST_PLAYING: begin
                // Crash wins over pause and suppresses any pass this cycle.
                if (crash) begin
                    lives_d = lives_left - 4'd1;
                    if (lives_left == 4'd1) begin
                        state_d = ST_GAMEOVER;
                        if (score > high_score) begin
                            high_d = score;
                            nrec_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_DYING;
                        cnt_d   = '0;
                    end
                end else begin
                    score_d = score_sat;
                    if (pause_p) state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (restart_p)    state_d = ST_IDLE;
                else if (pause_p) state_d = ST_PLAYING;
            end
            ST_DYING: begin
                if (vs_p) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_DONE) state_d = ST_PLAYING;
                end
            end
            ST_GAMEOVER: begin
                if (restart_p) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every entry into IDLE starts a fresh game; high_score survives.
        if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            score_d = '0;
            lives_d = LIVES_INIT;
        end
    end

    // ---- outputs ----
    logic [FLAG_W-1:0] flags;
    assign flags   = state_flags(state_q);
    assign waiting = flags[F_WAITING];
    assign play    = flags[F_PLAY];
    assign paused  = flags[F_PAUSED];
    assign dying   = flags[F_DYING];
    assign over    = flags[F_OVER];
    assign bird_en = vs_p & (state_q == ST_PLAYING);

endmodule

// File: tb/tb_game_fsm_multi.sv
// tb_game_fsm_multi -- scoreboard bench for game_fsm_multi.
// A driver applies one input vector per cycle, steps a behavioural game model
// and queues the expected outputs; an independent monitor pops and compares.
module tb_game_fsm_multi;

    localparam int NP = 3, SW = 12, LV = 3, RF = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam int MD_IDLE = 0, MD_PLAY = 1, MD_PAUSED = 2, MD_DYING = 3, MD_OVER = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          vs = 1'b0, start = 1'b0, pause = 1'b0, restart = 1'b0;
    logic [NP-1:0] crash_vec = '0, pass_vec = '0;
    logic          waiting, play, paused, dying, over, bird_en, new_record;
    logic [SW-1:0] score, high_score;
    logic [3:0]    lives_left;

    game_fsm_multi #(.NUM_PIPES(NP), .SCORE_W(SW), .LIVES(LV), .RESPAWN_FRAMES(RF)) dut (
        .clk(clk), .rst_n(rst_n), .vs(vs), .start(start), .pause(pause), .restart(restart),
        .crash_vec(crash_vec), .pass_vec(pass_vec),
        .waiting(waiting), .play(play), .paused(paused), .dying(dying), .over(over),
        .bird_en(bird_en), .score(score), .high_score(high_score), .lives_left(lives_left),
        .new_record(new_record)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     rst;
        bit     bird;
        bit [4:0] flags;   // {over,dying,paused,play,waiting}
        int     score;
        int     high;
        int     lives;
        bit     nrec;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

    // staged stimulus, applied by cyc() just after the next rising edge
    bit          s_rst_n = 0, s_vs = 0, s_start = 0, s_pause = 0, s_restart = 0;
    bit [NP-1:0] s_crash = 0, s_pass = 0;

    // behavioural game model
    int          m_mode = MD_IDLE, m_score = 0, m_high = 0, m_lives = LV, m_frames = 0;
    bit          m_pvs = 0, m_pst = 0, m_ppa = 0, m_prs = 0;
    bit [NP-1:0] m_ppass = 0;

    task automatic new_game();
        m_mode = MD_IDLE; m_score = 0; m_lives = LV;
    endtask

    task automatic cyc();
        exp_t        e;
        bit          vp, sp, pp, rp;
        bit [NP-1:0] pap;
        @(posedge clk); #2;
        rst_n = s_rst_n; vs = s_vs; start = s_start; pause = s_pause; restart = s_restart;
        crash_vec = s_crash; pass_vec = s_pass;
        e.nrec = 0;
        if (!s_rst_n) begin
            new_game(); m_high = 0; m_frames = 0;
            m_pvs = 0; m_pst = 0; m_ppa = 0; m_prs = 0; m_ppass = 0;
            e.rst = 1; e.bird = 0;
        end else begin
            e.rst = 0;
            vp = s_vs & ~m_pvs; sp = s_start & ~m_pst; pp = s_pause & ~m_ppa; rp = s_restart & ~m_prs;
            pap = s_pass & ~m_ppass;
            e.bird = vp && (m_mode == MD_PLAY);
            case (m_mode)
                MD_IDLE:   if (sp) m_mode = MD_PLAY;
                MD_PLAY:
                    if (s_crash != 0) begin
                        m_lives = m_lives - 1;
                        if (m_lives == 0) begin
                            m_mode = MD_OVER;
                            if (m_score > m_high) begin m_high = m_score; e.nrec = 1; end
                        end else begin
                            m_mode = MD_DYING; m_frames = 0;
                        end
                    end else begin
                        m_score = m_score + $countones(pap);
                        if (m_score > SMAX) m_score = SMAX;
                        if (pp) m_mode = MD_PAUSED;
                    end
                MD_PAUSED: if (rp) new_game(); else if (pp) m_mode = MD_PLAY;
                MD_DYING:  if (vp) begin m_frames++; if (m_frames == RF) m_mode = MD_PLAY; end
                MD_OVER:   if (rp) new_game();
                default:   new_game();
            endcase
            m_pvs = s_vs; m_pst = s_start; m_ppa = s_pause; m_prs = s_restart; m_ppass = s_pass;
        end
        e.flags = 5'b00001 << m_mode;
        e.score = m_score; e.high = m_high; e.lives = m_lives;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_regs(input exp_t e);
        chk("flags", int'({over, dying, paused, play, waiting}), int'(e.flags));
        chk("score", int'(score), e.score);
        chk("high_score", int'(high_score), e.high);
        chk("lives_left", int'(lives_left), e.lives);
        chk("new_record", int'(new_record), int'(e.nrec));
    endtask

    // monitor: bird_en is combinational from the current vector, so it is
    // sampled mid-cycle; registered outputs are sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("bird_en", int'(bird_en), int'(e.bird));
                if (e.rst) chk_regs(e);   // reset acts without waiting for a clock
                @(posedge clk); #1;
                chk_regs(e);
            end
        end
    end

    task automatic clr();
        s_vs = 0; s_start = 0; s_pause = 0; s_restart = 0; s_crash = 0; s_pass = 0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin s_vs = 1; cyc(); s_vs = 0; cyc(); end
    endtask

    task automatic press(input int which);   // 0 start, 1 pause, 2 restart
        if (which == 0) s_start = 1; else if (which == 1) s_pause = 1; else s_restart = 1;
        cyc();
        s_start = 0; s_pause = 0; s_restart = 0;
        cyc();
    endtask

    task automatic crash_once();
        s_crash = 3'b001; cyc(); s_crash = 0; cyc();
    endtask

    initial begin
        // reset, then start
        s_rst_n = 0; cyc(); cyc();
        s_rst_n = 1; cyc();
        press(0);
        // pass 101 then 111: +2 then +1, held bits not recounted
        s_pass = 3'b101; cyc(); s_pass = 3'b111; cyc(); s_pass = 0; cyc();
        s_pass = 3'b011; cyc(); s_pass = 0; cyc();          // score 5
        frames(2);                                           // bird_en while playing
        // crash with lives 3 -> DYING, lives 2; crash held in DYING ignored
        s_crash = 3'b010; cyc(); cyc(); s_pass = 3'b100; cyc(); s_crash = 0; s_pass = 0; cyc();
        frames(RF);                                          // back to PLAYING
        // pause and crash together: crash wins
        s_pause = 1; s_crash = 3'b001; cyc(); clr(); cyc();
        frames(RF);
        // pause: no bird_en, pass/crash ignored
        press(1);
        s_pass = 3'b111; s_crash = 3'b100; frames(2); clr(); cyc();
        press(1);
        s_pass = 3'b001; cyc(); s_pass = 0; cyc();           // score 6
        crash_once();                                        // last life -> GAMEOVER, record
        cyc();
        // restart and a lower second game: no record
        press(2);
        press(0);
        s_pass = 3'b010; cyc(); s_pass = 0; cyc();
        crash_once(); frames(RF);
        crash_once(); frames(RF);
        crash_once(); cyc();
        press(2);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            s_rst_n   = ($urandom_range(0, 599) != 0);
            s_vs      = $urandom_range(0, 1);
            s_start   = ($urandom_range(0, 9) == 0);
            s_pause   = ($urandom_range(0, 19) == 0);
            s_restart = ($urandom_range(0, 29) == 0);
            s_crash   = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            s_pass    = 3'($urandom_range(0, 7));
            cyc();
        end
        clr();

        // saturation: climb to 4094, then 3 pipes at once
        s_rst_n = 0; cyc(); s_rst_n = 1; cyc();
        press(0);
        for (int i = 0; i < 1364; i++) begin s_pass = 3'b111; cyc(); s_pass = 0; cyc(); end
        s_pass = 3'b011; cyc(); s_pass = 0; cyc();           // 4094
        s_pass = 3'b111; cyc(); s_pass = 0; cyc();           // 4095
        s_pass = 3'b001; cyc(); s_pass = 0; cyc();           // stays 4095
        // reset mid-DYING discards everything; start held across release
        crash_once(); frames(1);
        s_start = 1; s_rst_n = 0; cyc(); cyc();
        s_rst_n = 1; cyc();
        s_start = 0; cyc(); cyc();

        repeat (4) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
